// File: rtl/game_master_pkg.sv
// Shared state encoding and width helpers for the game master controller.
package game_master_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_AIM   = 2'd1,
        ST_SHOOT = 2'd2,
        ST_END   = 2'd3
    } gm_state_t;

    // Bits needed to hold the values 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/game_score_counter.sv
// Saturating score register: adds the popcount of a hit vector each cycle,
// with a synchronous clear that starts a fresh game.
module game_score_counter
    import game_master_pkg::*;
#(
    parameter int N_HITS  = 2,
    parameter int SCORE_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic [N_HITS-1:0]  hit_i,
    output logic [SCORE_W-1:0] score_o
);
    localparam int CW   = cnt_w(N_HITS);
    localparam int SUMW = ((SCORE_W > CW) ? SCORE_W : CW) + 1;

    logic [SCORE_W-1:0] score_q;
    logic [CW-1:0]      cnt;
    logic [SUMW-1:0]    sum;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_HITS; i++) begin
            cnt = cnt + CW'(hit_i[i]);
        end
        sum = SUMW'(score_q) + SUMW'(cnt);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            score_q <= '0;
        end else if (sum[SUMW-1:SCORE_W] != '0) begin
            score_q <= '1;
        end else begin
            score_q <= sum[SCORE_W-1:0];
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/game_master_fsm_multi.sv
// Game master: sequences one torpedo against N_TARGETS tracked targets with a
// per-round shot budget, a saturating score and a difficulty level.
module game_master_fsm_multi
    import game_master_pkg::*;
#(
    parameter int N_TARGETS = 2,
    parameter int SHOTS     = 3,
    parameter int SCORE_W   = 8,
    parameter int LEVEL_MAX = 3,
    parameter int END_BLANK = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        key,
    output logic [N_TARGETS-1:0]        target_write_xy,
    output logic                        torpedo_write_xy,
    output logic [N_TARGETS-1:0]        target_write_dxy,
    output logic                        torpedo_write_dxy,
    output logic [N_TARGETS-1:0]        target_enable_update,
    output logic                        torpedo_enable_update,
    input  logic [N_TARGETS-1:0]        target_within_screen,
    input  logic                        torpedo_within_screen,
    input  logic [N_TARGETS-1:0]        collision,
    output logic                        end_of_game_timer_start,
    input  logic                        end_of_game_timer_running,
    output logic                        game_won,
    output logic [cnt_w(SHOTS)-1:0]     shots_left,
    output logic [SCORE_W-1:0]          score,
    output logic [cnt_w(LEVEL_MAX)-1:0] level
);
    localparam int SW = cnt_w(SHOTS);
    localparam int LW = cnt_w(LEVEL_MAX);
    localparam int BW = cnt_w(END_BLANK);

    gm_state_t          state_q, state_d;
    logic [N_TARGETS-1:0] alive_q, alive_d;
    logic [SW-1:0]      shots_q, shots_d;
    logic [LW-1:0]      level_q, level_d;
    logic [BW-1:0]      blank_q, blank_d;
    logic               lost_q, lost_d, won_q, won_d;
    logic [N_TARGETS-1:0] twxy_q, twxy_d, twdxy_q, twdxy_d, ten_q, ten_d;
    logic               pwxy_q, pwxy_d, pwdxy_q, pwdxy_d, pen_q, pen_d;
    logic               tstart_q, tstart_d;
    logic [N_TARGETS-1:0] hit, escape;
    logic               score_clr, win, lose;

    always_comb begin
        state_d   = state_q;
        alive_d   = alive_q;
        shots_d   = shots_q;
        level_d   = level_q;
        blank_d   = blank_q;
        lost_d    = lost_q;
        won_d     = won_q;
        twxy_d    = '0;
        twdxy_d   = '0;
        pwxy_d    = 1'b0;
        pwdxy_d   = 1'b0;
        tstart_d  = 1'b0;
        hit       = '0;
        score_clr = 1'b0;
        win       = 1'b0;
        lose      = 1'b0;
        // Dead targets never count as escaping.
        escape    = alive_q & ~target_within_screen;

        case (state_q)
            ST_START: begin
                twxy_d    = '1;
                twdxy_d   = '1;
                pwxy_d    = 1'b1;
                alive_d   = '1;
                shots_d   = SW'(SHOTS);
                won_d     = 1'b0;
                lost_d    = 1'b0;
                score_clr = lost_q;
                if (lost_q) level_d = '0;
                state_d   = ST_AIM;
            end
            ST_AIM: begin
                if (escape != '0) begin
                    lose = 1'b1;
                end else if (key && shots_q != '0) begin
                    pwdxy_d = 1'b1;
                    shots_d = shots_q - 1'b1;
                    state_d = ST_SHOOT;
                end
            end
            ST_SHOOT: begin
                hit = collision & alive_q;
                if (hit != '0) begin
                    alive_d = alive_q & ~hit;
                    pwxy_d  = 1'b1;
                    if (alive_d == '0) begin
                        win   = 1'b1;
                        won_d = 1'b1;
                        if (level_q != LW'(LEVEL_MAX)) level_d = level_q + 1'b1;
                    end else begin
                        state_d = ST_AIM;
                    end
                end else if (escape != '0) begin
                    lose = 1'b1;
                end else if (!torpedo_within_screen) begin
                    pwxy_d = 1'b1;
                    if (shots_q != '0) state_d = ST_AIM;
                    else               lose    = 1'b1;
                end
            end
            ST_END: begin
                if (blank_q != '0)                   blank_d = blank_q - 1'b1;
                else if (!end_of_game_timer_running) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase

        if (win || lose) begin
            tstart_d = 1'b1;
            lost_d   = lose;
            blank_d  = BW'(END_BLANK);
            state_d  = ST_END;
        end

        ten_d = (state_d == ST_AIM || state_d == ST_SHOOT) ? alive_d : '0;
        pen_d = (state_d == ST_SHOOT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_START;
            alive_q  <= '0;
            shots_q  <= '0;
            level_q  <= '0;
            blank_q  <= '0;
            lost_q   <= 1'b0;
            won_q    <= 1'b0;
            twxy_q   <= '0;
            twdxy_q  <= '0;
            ten_q    <= '0;
            pwxy_q   <= 1'b0;
            pwdxy_q  <= 1'b0;
            pen_q    <= 1'b0;
            tstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            alive_q  <= alive_d;
            shots_q  <= shots_d;
            level_q  <= level_d;
            blank_q  <= blank_d;
            lost_q   <= lost_d;
            won_q    <= won_d;
            twxy_q   <= twxy_d;
            twdxy_q  <= twdxy_d;
            ten_q    <= ten_d;
            pwxy_q   <= pwxy_d;
            pwdxy_q  <= pwdxy_d;
            pen_q    <= pen_d;
            tstart_q <= tstart_d;
        end
    end

    game_score_counter #(
        .N_HITS  (N_TARGETS),
        .SCORE_W (SCORE_W)
    ) u_score (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .clr_i   (score_clr),
        .hit_i   (hit),
        .score_o (score)
    );

    assign target_write_xy         = twxy_q;
    assign torpedo_write_xy        = pwxy_q;
    assign target_write_dxy        = twdxy_q;
    assign torpedo_write_dxy       = pwdxy_q;
    assign target_enable_update    = ten_q;
    assign torpedo_enable_update   = pen_q;
    assign end_of_game_timer_start = tstart_q;
    assign game_won                = won_q;
    assign shots_left              = shots_q;
    assign level                   = level_q;

endmodule

// File: doc/game_master_fsm_multi.md
Name: game_master_fsm_multi

Overview:
Next-generation game master controller. It sequences one torpedo against N_TARGETS independently tracked targets, with a limited shot budget per round, a saturating score and a difficulty level. It sits between the sprite instances, the collision detector and the end-of-game timer. It drives per-sprite write/update strobes and exposes game status to the display logic.

Parameters:
N_TARGETS, 2, number of target sprites (1..8)
SHOTS, 3, torpedoes available per round (1..15)
SCORE_W, 8, score counter width
LEVEL_MAX, 3, highest difficulty level; level output width is clog2(LEVEL_MAX+1)
END_BLANK, 2, cycles in END before end_of_game_timer_running is sampled (>=2)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
key  in  1  fire request, level-sensitive
target_write_xy  out  N_TARGETS  load start position, per target
torpedo_write_xy  out  1  load/reload torpedo start position
target_write_dxy  out  N_TARGETS  load velocity (level-dependent), per target
torpedo_write_dxy  out  1  load torpedo launch velocity
target_enable_update  out  N_TARGETS  per-target motion enable
torpedo_enable_update  out  1  torpedo motion enable
target_within_screen  in  N_TARGETS  per-target on-screen flag
torpedo_within_screen  in  1  torpedo on-screen flag
collision  in  N_TARGETS  torpedo/target[i] overlap
end_of_game_timer_start  out  1  one-cycle timer start pulse
end_of_game_timer_running  in  1  timer busy
game_won  out  1  result of last round, held until next START
shots_left  out  clog2(SHOTS+1)  remaining torpedoes
score  out  SCORE_W  saturating hit count
level  out  clog2(LEVEL_MAX+1)  difficulty level

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low. All outputs are registered and take effect one cycle after the decision cycle.
- Reset values: all strobes/enables 0, game_won 0, score 0, level 0, shots_left 0. Internal state: START, alive mask 0. Asserting reset_n low mid-round aborts immediately, with no timer pulse.
- States: START, AIM, SHOOT, END.
- START (1 cycle):
  - pulse all target_write_xy, torpedo_write_xy and all target_write_dxy.
  - alive <= all ones; shots_left <= SHOTS; game_won <= 0.
  - If the previous round was lost, score <= 0 and level <= 0.
  - Next state AIM.
- AIM:
  - target_enable_update = alive.
  - Any alive target with target_within_screen=0 -> lost (timer pulse, END).
  - Otherwise key=1 -> pulse torpedo_write_dxy, shots_left-1, SHOOT.
  - Loss has priority over key in the same cycle.
- SHOOT:
  - target_enable_update = alive; torpedo_enable_update = 1; key is ignored.
  - Hit set H = collision & alive. If H != 0: clear H from alive; score += popcount(H), saturating at 2^SCORE_W-1; pulse torpedo_write_xy.
    - alive becomes 0 -> won: game_won <= 1; level +1, saturating at LEVEL_MAX; timer pulse; END.
    - Otherwise -> AIM.
  - Else, if an alive target leaves the screen -> lost (END).
  - Else, if torpedo_within_screen=0: pulse torpedo_write_xy; go to AIM if shots_left>0, else lost (END).
  - Priority: hit > target escape > torpedo miss.
  - collision or within_screen bits of dead targets are ignored everywhere.
- END:
  - All enables 0.
  - A blank counter holds the FSM for END_BLANK cycles.
  - After that, it returns to START on the first cycle with end_of_game_timer_running=0.
  - end_of_game_timer_start is exactly one cycle wide per round.
- Lost flag: an internal register, set on every loss and cleared on every win. START consumes it.
- Width rule: shots_left never underflows, because the decrement only happens on a valid fire.

Decomposition:
- Shared package game_master_pkg: state encoding localparams, shots/level width functions (clog2).
- One sub-module, game_score_counter: popcount of an N_TARGETS hit vector plus saturating add, with synchronous clear.

Test Plan:
1. N_TARGETS=2: reset_n low 3 cycles, then high -> one START cycle with target_write_xy=2'b11; AIM; shots_left=3, score=0.
2. key in AIM, then collision=2'b01, later collision=2'b10 -> score 1 then 2; alive 10 then 00; game_won=1; exactly one timer_start pulse; level=1.
3. Three launches, each ending with torpedo_within_screen=0 and no hit -> shots_left 2,1,0; third miss -> END with game_won=0; next START clears score and level to 0.
4. collision=2'b11 in the same cycle -> score +2 in one step; win on that cycle; torpedo miss asserted in the same cycle is ignored.
5. score preloaded to 255 via repeated wins (SCORE_W=8) -> stays 255 on further hits; level saturates at 3.
6. reset_n low during SHOOT -> next cycle all outputs at reset values; no timer pulse; END holds while timer_running=1 and exits 1 cycle after it drops.
